// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port synchronous RAM: write bursts stream
// beats into consecutive words, read bursts return words through a 2-entry buffer.
module ram_burst_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Every stream moves one item on a cycle where its valid and ready are both
  // high at the rising edge; valid never waits on ready.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            count_q, count_d;

  logic                  req_hs;
  logic                  wr_hs;
  logic                  beats_left;
  logic                  last_beat;
  logic                  pop;
  logic                  push;
  logic [2:0]            occ;
  logic                  rd_issue;
  logic                  rd_finish;

  // cnt_q counts beats accepted (write) or reads issued (read) in this burst.
  assign req_hs     = (state_q == S_IDLE) & req_valid;
  assign wr_hs      = (state_q == S_WRITE) & wr_valid;
  assign beats_left = (cnt_q <= {1'b0, len_q});
  assign last_beat  = (cnt_q == {1'b0, len_q});
  assign pop        = (count_q != 2'd0) & rd_ready;
  assign push       = inflight_q;

  // Buffered plus in-flight words after this cycle's pop must leave room for one more.
  assign occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue   = (state_q == S_READ) & beats_left & (occ <= 3'd1);
  assign rd_finish  = (state_q == S_READ) & ~beats_left & ~inflight_q &
                      (count_q == {1'b0, pop});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      count_q    <= count_d;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
    end
  end

  // Buffer storage carries no reset; only the occupancy count matters after reset.
  always_ff @(posedge clk) begin
    if (push) buf_q[wptr_q] <= ram_rdata;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    inflight_d = rd_issue;
    done_d     = (wr_hs & last_beat) | rd_finish;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = req_write ? S_WRITE : S_READ;
          addr_d  = req_addr;
          len_d   = req_len;
          cnt_d   = '0;
        end
      end
      S_WRITE: begin
        if (wr_hs) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last_beat) state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_issue) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
        if (rd_finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    wr_ready  = (state_q == S_WRITE);
    busy      = (state_q != S_IDLE);
    done      = done_q;
    rd_valid  = (count_q != 2'd0);
    rd_data   = rd_valid ? buf_q[rptr_q] : '0;
    ram_cs    = wr_hs | rd_issue;
    ram_we    = wr_hs;
    ram_oe    = ram_cs & ~ram_we;
    ram_addr  = ram_cs ? addr_q : '0;
    ram_wdata = wr_hs ? wr_data : '0;
  end

  logic unused_req_hs;
  assign unused_req_hs = req_hs;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural RAM, reference memory, queue scoreboard
// for RAM writes, read-issue addresses and read beats.
module tb_ram_burst_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int LW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM with registered read data.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else if (ram_oe) ram_rdata <= ram_mem[ram_addr];
    end
  end

  logic [DW-1:0]    ref_mem [DEPTH];
  logic [DW-1:0]    exp_q [$];
  logic [AW+DW-1:0] wr_exp_q [$];
  logic [AW-1:0]    rd_addr_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int outstanding = 0;
  int pops = 0;
  int last_pop_cyc = 0;
  int busy_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an unexpected or missing event, required none", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a RAM access or a read beat.
  always @(negedge clk) begin
    logic issue;
    logic pop_now;
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      issue   = ram_cs && !ram_we;
      pop_now = rd_valid && rd_ready;
      check("ram_oe", ram_oe, ram_cs & ~ram_we);
      if (ram_cs && ram_we) begin
        if (wr_exp_q.size() == 0) fail("ram_write_unexpected");
        else check("ram_write", {ram_addr, ram_wdata}, wr_exp_q.pop_front());
      end
      if (issue) begin
        if (rd_addr_q.size() == 0) fail("ram_read_unexpected");
        else check("ram_read_addr", ram_addr, rd_addr_q.pop_front());
        check("read_occupancy", (outstanding + 1 - int'(pop_now)) <= 2, 1'b1);
      end
      if (pop_now) begin
        if (exp_q.size() == 0) fail("rd_beat_unexpected");
        else check("rd_data", rd_data, exp_q.pop_front());
        pops++;
        last_pop_cyc = cyc;
      end
      outstanding = outstanding + int'(issue) - int'(pop_now);
      if (busy) busy_cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic w, input logic [AW-1:0] a, input int len);
    int k = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = len[LW-1:0];
    while (!req_ready && k < 100) begin
      step();
      k++;
    end
    if (!req_ready) fail("req_timeout");
    hs_cyc = cyc;
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  // Waits for the first idle cycle, then checks the single done pulse.
  task automatic finish_burst(input string name);
    int k = 0;
    while (busy && k < 400) begin
      step();
      k++;
    end
    if (busy) fail({name, "_timeout"});
    check({name, "_done"}, done, 1'b1);
    step();
    check({name, "_done_single"}, done, 1'b0);
  endtask

  // mode 0: continuous wr_valid, 1: pattern 1,0,0,1,0,1, else random
  task automatic write_burst(input logic [AW-1:0] addr, input int len, input int mode,
                             input logic chk_busy);
    logic [AW-1:0] a = addr;
    logic [5:0]    pat = 6'b101001;
    logic [DW-1:0] d;
    logic          v;
    int            n = 0;
    int            j = 0;
    busy_cyc = 0;
    send_req(1'b1, addr, len);
    while (n <= len && j < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = pat[j % 6];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (mode == 2) ? DW'($urandom) : (32'hA000_0000 | (32'(addr) << 8) | 32'(n));
      wr_valid = v;
      wr_data  = d;
      if (v && wr_ready) begin
        wr_exp_q.push_back({a, d});
        ref_mem[a] = d;
        a = a + 1'b1;
        n++;
      end
      step();
      j++;
    end
    wr_valid = 1'b0;
    if (n <= len) fail("write_beat_timeout");
    if (chk_busy) check("write_busy_cycles", busy_cyc, len + 1);
    finish_burst("write");
    check("write_beats_left", wr_exp_q.size(), 0);
  endtask

  // mode 0: rd_ready high, 1: low for T+2..T+8 then toggling, else random
  task automatic read_burst(input logic [AW-1:0] addr, input int len, input int mode,
                            input logic chk_lat);
    logic [AW-1:0] a = addr;
    int            k = 1;
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back(ref_mem[a]);
      rd_addr_q.push_back(a);
      a = a + 1'b1;
    end
    rd_ready = (mode != 1);
    send_req(1'b0, addr, len);
    while (busy && k < 400) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k >= 2 && k <= 8) ? 1'b0 : k[0];
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (chk_lat && k <= 3) check($sformatf("rd_latency_t%0d", k), rd_valid, k == 3);
      step();
      k++;
    end
    rd_ready = 1'b0;
    if (busy) fail("read_timeout");
    if (mode == 0) check("read_throughput", cyc, hs_cyc + len + 4);
    check("done_after_last_pop", cyc, last_pop_cyc + 1);
    check("read_beats_left", exp_q.size(), 0);
    check("read_issues_left", rd_addr_q.size(), 0);
    finish_burst("read");
  endtask

  task automatic reset_mid_read(input logic [AW-1:0] addr, input int len);
    int p0 = pops;
    int k = 0;
    logic [AW-1:0] a = addr;
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back(ref_mem[a]);
      rd_addr_q.push_back(a);
      a = a + 1'b1;
    end
    rd_ready = 1'b1;
    send_req(1'b0, addr, len);
    while (pops < p0 + 2 && k < 100) begin
      step();
      k++;
    end
    if (pops < p0 + 2) fail("mid_read_timeout");
    rst_n = 1'b0;
    rd_ready = 1'b0;
    exp_q.delete();
    rd_addr_q.delete();
    step();
    rst_n = 1'b1;
    check("mid_reset_rd_valid", rd_valid, 1'b0);
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_req_ready", req_ready, 1'b1);
    check("mid_reset_done", done, 1'b0);
    step();
    check("mid_reset_done_later", done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    check("reset_ctrl", {busy, rd_valid, done, ram_cs, ram_we, ram_oe, wr_ready, req_ready},
          8'b0000_0001);
    check("reset_ram_bus", {ram_addr, ram_wdata, rd_data}, '0);
    rst_n = 1'b1;
    step();

    write_burst(4'd0, 15, 2, 1'b0);
    write_burst(4'd2, 3, 0, 1'b1);
    read_burst(4'd2, 3, 0, 1'b1);
    write_burst(4'd14, 3, 0, 1'b1);
    read_burst(4'd14, 3, 0, 1'b1);
    read_burst(4'd2, 7, 1, 1'b0);
    write_burst(4'd6, 2, 1, 1'b0);
    read_burst(4'd6, 2, 2, 1'b0);
    reset_mid_read(4'd0, 5);
    read_burst(4'd3, 0, 0, 1'b1);

    repeat (30) begin
      logic [AW-1:0] a;
      int            len;
      a   = AW'($urandom_range(0, DEPTH - 1));
      len = $urandom_range(0, (1 << LW) - 1);
      if ($urandom_range(0, 1) == 1) write_burst(a, len, 2, 1'b0);
      else read_burst(a, len, 2, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Burst sequencer that drives the team's single-port synchronous RAM (cs/we/oe/addr/data_in, registered data_out) from a valid/ready request interface. Accepts one burst command at a time. For write bursts, streams write beats into consecutive RAM words. For read bursts, issues RAM reads and delivers the returned words on a back-pressurable read stream through a 2-entry buffer. Sits directly upstream of the RAM; all RAM access goes through this block.

Parameters:
ADDR_WIDTH, 4, RAM address width; RAM depth is 2^ADDR_WIDTH, addresses wrap modulo depth
DATA_WIDTH, 32, RAM word width
LEN_WIDTH, 4, burst length field width; burst carries req_len+1 beats (1..2^LEN_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  burst command valid
req_ready  output  1  command accepted when req_valid&req_ready
req_write  input  1  1=write burst, 0=read burst
req_addr  input  ADDR_WIDTH  start address
req_len  input  LEN_WIDTH  beats minus one
wr_valid  input  1  write beat valid
wr_ready  output  1  write beat accepted
wr_data  input  DATA_WIDTH  write beat data
rd_valid  output  1  read beat valid
rd_ready  input  1  consumer accepts read beat
rd_data  output  DATA_WIDTH  read beat data
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on burst completion
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_oe  output  1  RAM output enable, = ram_cs & ~ram_we
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_rdata  input  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, beat counter 0, buffer empty, in-flight flag 0. All outputs 0 except req_ready, which is 1 once in IDLE.
- States: IDLE, WRITE, READ.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr and len, then go to WRITE or READ per req_write.
  - Other states: req_ready=0.
- WRITE:
  - wr_ready=1.
  - On wr_valid: drive ram_cs=1, ram_we=1, ram_addr=cur_addr, ram_wdata=wr_data combinationally; the RAM commits at that edge.
  - Advance cur_addr (+1, wrap) and the beat count.
  - Cycles without wr_valid: ram_cs=0, nothing advances.
  - After the handshake of beat len+1, go to IDLE.
- READ, issue side:
  - Issue when beats remain and (buf_count + inflight - pop) <= 1, where pop = rd_valid & rd_ready.
  - Issue drives ram_cs=1, ram_we=0, ram_addr=cur_addr; advance cur_addr and the issue count.
  - inflight is set on issue and cleared the following cycle.
- READ, capture and drain:
  - In the cycle after an issue, ram_rdata is pushed into the 2-entry FIFO.
  - rd_valid = buffer non-empty; rd_data = head entry.
  - Latency: command handshake in cycle T gives first issue at T+1, capture at the end of T+2, rd_valid at T+3.
  - Sustains 1 beat/cycle when rd_ready is held high.
- READ, exit: after the final beat is popped (all issued, inflight=0, buffer empty), go to IDLE.
- Buffer must never overflow and order must be preserved; the issue condition above guarantees this under any rd_ready pattern.
- done: one-cycle pulse in the first IDLE cycle after a completed burst. A new request may be accepted in that same cycle.
- Address wrap: address 2^ADDR_WIDTH-1 is followed by 0.
- Unused inputs: wr_valid is ignored outside WRITE; rd_ready is ignored when rd_valid=0.
- Reset mid-burst: burst aborted, buffer and inflight data discarded, no done pulse.

Test Plan:
- Write burst: addr=2, len=3, wr_data A0..A3 with continuous wr_valid -> RAM words 2..5 = A0..A3; done pulses once; busy high for exactly 4 cycles.
- Read back: addr=2, len=3, rd_ready=1 -> rd_valid first at T+3, then A0..A3 on consecutive cycles; done one cycle after the last pop.
- Wrap: write addr=14, len=3 -> RAM words 14,15,0,1 written; read addr=14, len=3 returns the same data in order.
- Read backpressure: len=7, rd_ready low for cycles T+2..T+8, then toggling -> exactly 8 beats, in order, no loss or duplication; no RAM read issued while buffer+inflight would exceed 2.
- Write bubbles: len=2 with wr_valid pattern 1,0,0,1,0,1 -> ram_cs high only on the 3 valid cycles; addresses consecutive.
- Reset mid-read: assert rst_n=0 after 2 beats of a len=5 read -> next cycle rd_valid=0, busy=0, req_ready=1, no done pulse; a subsequent len=0 read returns a single correct beat.
